dmem_issue_ctrl: RTL and testbench

DMEM_ISSUE_CTRL -- requirements
Module: dmem_issue_ctrl

---
 rtl/rv32i_types.sv | 53 +++++
 rtl/dmem_pack.sv | 84 ++++++++
 rtl/dmem_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I load/store types: LSQ entry layout, opcode and funct3 encodings,
// the memory-issue controller state enum and a byte-lane mask helper.
package rv32i_types;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
  } lsq_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } dmem_ctrl_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Byte-lane mask for an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_pack.sv
// Combinational request alignment: word-aligned address, byte-lane masks and
// lane-shifted store data for one LSQ entry. All outputs are zero when not
// enabled or when funct3 does not encode a legal access of the given type.
module dmem_pack
  import rv32i_types::*;
(
  input  logic        en_i,
  input  logic        is_store_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] addr_o,
  output logic [3:0]  rmask_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o
);

  logic [1:0]  off_s;
  logic [4:0]  shamt_s;
  logic [31:0] word_addr_s;

  assign off_s       = addr_i[1:0];
  assign shamt_s     = {off_s, 3'b000};
  assign word_addr_s = {addr_i[31:2], 2'b00};

  // Decode funct3 into masks/data lanes for the registered access.
  always_comb begin
    addr_o  = 32'h0000_0000;
    rmask_o = 4'b0000;
    wmask_o = 4'b0000;
    wdata_o = 32'h0000_0000;
    if (en_i) begin
      if (is_store_i) begin
        case (funct3_i)
          SB: begin
            addr_o  = word_addr_s;
            wmask_o = lane_mask(SZ_BYTE, off_s);
            wdata_o = {24'h00_0000, data_i[7:0]} << shamt_s;
          end
          SH: begin
            addr_o  = word_addr_s;
            wmask_o = lane_mask(SZ_HALF, off_s);
            wdata_o = {16'h0000, data_i[15:0]} << shamt_s;
          end
          SW: begin
            addr_o  = word_addr_s;
            wmask_o = lane_mask(SZ_WORD, off_s);
            wdata_o = data_i;
          end
          default: begin
            addr_o  = 32'h0000_0000;
            wmask_o = 4'b0000;
            wdata_o = 32'h0000_0000;
          end
        endcase
      end else begin
        case (funct3_i)
          LB, LBU: begin
            addr_o  = word_addr_s;
            rmask_o = lane_mask(SZ_BYTE, off_s);
          end
          LH, LHU: begin
            addr_o  = word_addr_s;
            rmask_o = lane_mask(SZ_HALF, off_s);
          end
          LW: begin
            addr_o  = word_addr_s;
            rmask_o = lane_mask(SZ_WORD, off_s);
          end
          default: begin
            addr_o  = 32'h0000_0000;
            rmask_o = 4'b0000;
          end
        endcase
      end
    end else begin
      addr_o  = 32'h0000_0000;
      rmask_o = 4'b0000;
      wmask_o = 4'b0000;
      wdata_o = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/dmem_issue_ctrl.sv
// Data-memory issue controller: arbitrates between the load-queue head and the
// committed store-queue head, keeps one request outstanding, and handles flush
// of speculative loads (stores always complete). Store grants are bounded to
// STORE_STREAK_MAX in a row while a load is waiting.
module dmem_issue_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned STORE_STREAK_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ld_req_valid,
  input  lsq_t        ld_req,
  output logic        ld_req_ready,
  input  logic        st_req_valid,
  input  lsq_t        st_req,
  output logic        st_req_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        ld_done_valid,
  output lsq_t        ld_done_entry,
  output logic [31:0] ld_done_rdata,
  output logic        st_done_valid
);

  localparam int unsigned STREAK_W = (STORE_STREAK_MAX < 1) ? 1 : $clog2(STORE_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STORE_STREAK_MAX);

  dmem_ctrl_state_t    state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  lsq_t                entry_q, entry_d;
  logic                is_store_q, is_store_d;
  logic                ld_done_valid_q, ld_done_valid_d;
  logic                st_done_valid_q, st_done_valid_d;
  lsq_t                ld_done_entry_q, ld_done_entry_d;
  logic [31:0]         ld_done_rdata_q, ld_done_rdata_d;
  logic                pack_en_s;
  logic                ld_grant_s;
  logic                st_grant_s;

  // State, streak, entry and completion registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      streak_q        <= '0;
      entry_q         <= '0;
      is_store_q      <= 1'b0;
      ld_done_valid_q <= 1'b0;
      st_done_valid_q <= 1'b0;
      ld_done_entry_q <= '0;
      ld_done_rdata_q <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      streak_q        <= streak_d;
      entry_q         <= entry_d;
      is_store_q      <= is_store_d;
      ld_done_valid_q <= ld_done_valid_d;
      st_done_valid_q <= st_done_valid_d;
      ld_done_entry_q <= ld_done_entry_d;
      ld_done_rdata_q <= ld_done_rdata_d;
    end
  end

  // Arbitration, next-state and completion logic.
  always_comb begin
    state_d         = state_q;
    streak_d        = streak_q;
    entry_d         = entry_q;
    is_store_d      = is_store_q;
    ld_done_valid_d = 1'b0;
    st_done_valid_d = 1'b0;
    ld_done_entry_d = ld_done_entry_q;
    ld_done_rdata_d = ld_done_rdata_q;
    ld_req_ready    = 1'b0;
    st_req_ready    = 1'b0;
    pack_en_s       = 1'b0;

    // Load wins only when no store is offered or the store streak is used up;
    // a flush blocks loads but leaves stores grantable.
    if (state_q == IDLE) begin
      if (!flush && ld_req_valid && (!st_req_valid || (streak_q == STREAK_SAT))) begin
        ld_req_ready = 1'b1;
      end else begin
        st_req_ready = 1'b1;
      end
    end else begin
      ld_req_ready = 1'b0;
      st_req_ready = 1'b0;
    end

    ld_grant_s = ld_req_valid && ld_req_ready;
    st_grant_s = st_req_valid && st_req_ready;

    if (!ld_req_valid || ld_grant_s) begin
      streak_d = '0;
    end else if (st_grant_s && (streak_q != STREAK_SAT)) begin
      streak_d = streak_q + STREAK_W'(1);
    end else begin
      streak_d = streak_q;
    end

    case (state_q)
      IDLE: begin
        if (st_grant_s) begin
          entry_d    = st_req;
          is_store_d = 1'b1;
          state_d    = ISSUE;
        end else if (ld_grant_s) begin
          entry_d    = ld_req;
          is_store_d = 1'b0;
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // A flushed load never reaches memory.
        if (!is_store_q && flush) begin
          state_d = IDLE;
        end else begin
          pack_en_s = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          state_d = IDLE;
          if (is_store_q) begin
            st_done_valid_d = 1'b1;
          end else if (!flush) begin
            ld_done_valid_d = 1'b1;
            ld_done_entry_d = entry_q;
            ld_done_rdata_d = dmem_rdata;
          end else begin
            ld_done_valid_d = 1'b0;
          end
        end else if (!is_store_q && flush) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (dmem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  dmem_pack u_pack (
    .en_i       (pack_en_s),
    .is_store_i (is_store_q),
    .addr_i     (entry_q.addr),
    .data_i     (entry_q.data),
    .funct3_i   (entry_q.funct3),
    .addr_o     (dmem_addr),
    .rmask_o    (dmem_rmask),
    .wmask_o    (dmem_wmask),
    .wdata_o    (dmem_wdata)
  );

  assign ld_done_valid = ld_done_valid_q;
  assign ld_done_entry = ld_done_entry_q;
  assign ld_done_rdata = ld_done_rdata_q;
  assign st_done_valid = st_done_valid_q;

endmodule

// File: tb/tb_dmem_issue_ctrl.sv
// Directed bench for dmem_issue_ctrl: reset state, sb/sh/lh alignment,
// store/load arbitration with the store-streak limit, flush in ISSUE/WAIT/DRAIN,
// invalid funct3 and reset during an outstanding load.
module tb_dmem_issue_ctrl;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ld_req_valid;
  lsq_t        ld_req;
  logic        ld_req_ready;
  logic        st_req_valid;
  lsq_t        st_req;
  logic        st_req_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        ld_done_valid;
  lsq_t        ld_done_entry;
  logic [31:0] ld_done_rdata;
  logic        st_done_valid;

  int n_cmp = 0;
  int n_err = 0;

  dmem_issue_ctrl #(.STORE_STREAK_MAX(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ld_req_valid  (ld_req_valid),
    .ld_req        (ld_req),
    .ld_req_ready  (ld_req_ready),
    .st_req_valid  (st_req_valid),
    .st_req        (st_req),
    .st_req_ready  (st_req_ready),
    .dmem_addr     (dmem_addr),
    .dmem_rmask    (dmem_rmask),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .ld_done_valid (ld_done_valid),
    .ld_done_entry (ld_done_entry),
    .ld_done_rdata (ld_done_rdata),
    .st_done_valid (st_done_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic lsq_t mk(input logic [3:0] tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d);
    lsq_t e;
    e.tag = tag; e.opcode = op; e.funct3 = f3; e.addr = a; e.data = d;
    return e;
  endfunction

  logic [7:0] exp_l;

  initial begin
    rst = 1'b1; flush = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
    ld_req = '0; st_req = '0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_rmask", dmem_rmask, 4'h0);
    chk("rst_wmask", dmem_wmask, 4'h0);
    chk("rst_ld_done", ld_done_valid, 1'b0);
    chk("rst_st_done", st_done_valid, 1'b0);
    chk("rst_st_ready", st_req_ready, 1'b1);
    chk("rst_ld_ready", ld_req_ready, 1'b0);
    tick();

    // sb 0xAB at 0x1003, response two cycles after issue
    st_req = mk(4'd1, OP_STORE, 3'b000, 32'h0000_1003, 32'h0000_00AB);
    st_req_valid = 1'b1;
    settle();
    chk("sb_st_ready", st_req_ready, 1'b1);
    chk("sb_ld_ready", ld_req_ready, 1'b0);
    tick(); st_req_valid = 1'b0; settle();
    chk("sb_addr", dmem_addr, 32'h0000_1000);
    chk("sb_wmask", dmem_wmask, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hAB00_0000);
    chk("sb_rmask", dmem_rmask, 4'h0);
    tick(); settle();
    chk("sb_wait_wmask", dmem_wmask, 4'h0);
    tick(); dmem_resp = 1'b1; settle();
    chk("sb_done_early", st_done_valid, 1'b0);
    tick(); dmem_resp = 1'b0; settle();
    chk("sb_done", st_done_valid, 1'b1);
    chk("sb_idle_ready", st_req_ready, 1'b1);
    tick(); settle();
    chk("sb_done_pulse", st_done_valid, 1'b0);

    // lh at 0x2002, minimum latency
    ld_req = mk(4'd5, OP_LOAD, 3'b001, 32'h0000_2002, 32'h0);
    ld_req_valid = 1'b1;
    settle();
    chk("lh_ld_ready", ld_req_ready, 1'b1);
    chk("lh_st_ready", st_req_ready, 1'b0);
    tick(); ld_req_valid = 1'b0; settle();
    chk("lh_rmask", dmem_rmask, 4'b1100);
    chk("lh_addr", dmem_addr, 32'h0000_2000);
    chk("lh_wmask", dmem_wmask, 4'h0);
    tick(); dmem_resp = 1'b1; dmem_rdata = 32'hBEEF_0000; settle();
    chk("lh_done_early", ld_done_valid, 1'b0);
    tick(); dmem_resp = 1'b0; dmem_rdata = 32'h0; settle();
    chk("lh_done", ld_done_valid, 1'b1);
    chk("lh_rdata", ld_done_rdata, 32'hBEEF_0000);
    chk("lh_entry", ld_done_entry, mk(4'd5, OP_LOAD, 3'b001, 32'h0000_2002, 32'h0));
    tick(); settle();
    chk("lh_done_pulse", ld_done_valid, 1'b0);

    // both heads valid continuously: S,S,S,L,S,S,S,L
    ld_req = mk(4'd2, OP_LOAD, 3'b010, 32'h0000_0200, 32'h0);
    st_req = mk(4'd3, OP_STORE, 3'b010, 32'h0000_0300, 32'h0000_0055);
    ld_req_valid = 1'b1; st_req_valid = 1'b1;
    exp_l = 8'b1000_1000;
    for (int g = 0; g < 8; g++) begin
      settle();
      chk($sformatf("arb%0d_ld_ready", g), ld_req_ready, exp_l[g]);
      chk($sformatf("arb%0d_st_ready", g), st_req_ready, !exp_l[g]);
      tick(); settle();
      chk($sformatf("arb%0d_rmask", g), dmem_rmask, exp_l[g] ? 4'hF : 4'h0);
      chk($sformatf("arb%0d_wmask", g), dmem_wmask, exp_l[g] ? 4'h0 : 4'hF);
      tick(); dmem_resp = 1'b1;
      tick(); dmem_resp = 1'b0; settle();
      chk($sformatf("arb%0d_ld_done", g), ld_done_valid, exp_l[g]);
      chk($sformatf("arb%0d_st_done", g), st_done_valid, !exp_l[g]);
    end
    ld_req_valid = 1'b0; st_req_valid = 1'b0;
    tick();

    // lbu at 0x3001, flush one cycle after issue, response three cycles later
    ld_req = mk(4'd7, OP_LOAD, 3'b100, 32'h0000_3001, 32'h0);
    ld_req_valid = 1'b1; settle();
    chk("drn_ld_ready", ld_req_ready, 1'b1);
    tick(); ld_req_valid = 1'b0; settle();
    chk("drn_rmask", dmem_rmask, 4'b0010);
    tick(); flush = 1'b1; settle();
    chk("drn_wait_ready", ld_req_ready, 1'b0);
    tick(); flush = 1'b0; ld_req_valid = 1'b1; settle();
    chk("drn_block1_ld", ld_req_ready, 1'b0);
    chk("drn_block1_st", st_req_ready, 1'b0);
    tick(); flush = 1'b1; settle();
    chk("drn_block2_ld", ld_req_ready, 1'b0);
    tick(); flush = 1'b0; dmem_resp = 1'b1; settle();
    chk("drn_block3_ld", ld_req_ready, 1'b0);
    tick(); dmem_resp = 1'b0; settle();
    chk("drn_no_done", ld_done_valid, 1'b0);
    chk("drn_regrant", ld_req_ready, 1'b1);
    ld_req_valid = 1'b0;
    tick();

    // flush in IDLE keeps stores grantable; store WAIT ignores flush
    flush = 1'b1; ld_req_valid = 1'b1; st_req_valid = 1'b1;
    ld_req = mk(4'd8, OP_LOAD, 3'b010, 32'h0000_5000, 32'h0);
    st_req = mk(4'd4, OP_STORE, 3'b010, 32'h0000_4000, 32'h1234_5678);
    settle();
    chk("fst_ld_ready", ld_req_ready, 1'b0);
    chk("fst_st_ready", st_req_ready, 1'b1);
    tick(); ld_req_valid = 1'b0; st_req_valid = 1'b0; settle();
    chk("fst_wmask", dmem_wmask, 4'hF);
    chk("fst_wdata", dmem_wdata, 32'h1234_5678);
    chk("fst_addr", dmem_addr, 32'h0000_4000);
    tick(); settle();
    chk("fst_wait_ready", st_req_ready, 1'b0);
    tick(); dmem_resp = 1'b1; settle();
    chk("fst_still_wait", st_req_ready, 1'b0);
    tick(); dmem_resp = 1'b0; flush = 1'b0; settle();
    chk("fst_done", st_done_valid, 1'b1);
    tick();

    // flush with a load in ISSUE: no request, back to IDLE; resp in IDLE ignored
    ld_req = mk(4'd9, OP_LOAD, 3'b010, 32'h0000_5000, 32'h0);
    ld_req_valid = 1'b1; settle();
    chk("fis_ld_ready", ld_req_ready, 1'b1);
    tick(); ld_req_valid = 1'b0; flush = 1'b1; settle();
    chk("fis_rmask", dmem_rmask, 4'h0);
    chk("fis_addr", dmem_addr, 32'h0);
    tick(); flush = 1'b0; dmem_resp = 1'b1; settle();
    chk("fis_idle", st_req_ready, 1'b1);
    chk("fis_idle_rmask", dmem_rmask, 4'h0);
    tick(); dmem_resp = 1'b0; settle();
    chk("fis_no_ld_done", ld_done_valid, 1'b0);
    chk("fis_no_st_done", st_done_valid, 1'b0);

    // flush coincident with resp in WAIT: IDLE, no completion
    ld_req = mk(4'd10, OP_LOAD, 3'b001, 32'h0000_6000, 32'h0);
    ld_req_valid = 1'b1;
    tick(); ld_req_valid = 1'b0;
    tick(); flush = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
    tick(); flush = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0; settle();
    chk("coin_no_done", ld_done_valid, 1'b0);
    chk("coin_idle", st_req_ready, 1'b1);

    // sh 0xCAFE at 0x7002
    st_req = mk(4'd6, OP_STORE, 3'b001, 32'h0000_7002, 32'h0000_CAFE);
    st_req_valid = 1'b1;
    tick(); st_req_valid = 1'b0; settle();
    chk("sh_wmask", dmem_wmask, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hCAFE_0000);
    tick(); dmem_resp = 1'b1;
    tick(); dmem_resp = 1'b0; settle();
    chk("sh_done", st_done_valid, 1'b1);

    // invalid funct3 load: nothing driven on the memory port
    ld_req = mk(4'd11, OP_LOAD, 3'b011, 32'h0000_8004, 32'h0);
    ld_req_valid = 1'b1;
    tick(); ld_req_valid = 1'b0; settle();
    chk("inv_rmask", dmem_rmask, 4'h0);
    chk("inv_addr", dmem_addr, 32'h0);
    tick(); dmem_resp = 1'b1;
    tick(); dmem_resp = 1'b0;

    // reset during WAIT abandons the outstanding load
    ld_req = mk(4'd12, OP_LOAD, 3'b010, 32'h0000_9000, 32'h0);
    ld_req_valid = 1'b1;
    tick(); ld_req_valid = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; settle();
    chk("rw_ld_done", ld_done_valid, 1'b0);
    chk("rw_entry", ld_done_entry, 80'h0);
    chk("rw_st_ready", st_req_ready, 1'b1);
    tick(); dmem_resp = 1'b1;
    tick(); dmem_resp = 1'b0; settle();
    chk("rw_stale_resp", ld_done_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
